// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - Sequential DES key schedule, one 48-bit round key per handshake
//
// Purpose: expands a 64-bit DES key into the sixteen round keys on the fly from a
// rotating C/D register pair. Keys are issued K1..K16 (encrypt) or K16..K1 (decrypt).
//
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        synchronous active-low reset
//   key_i[63:0]   DES key, key_i[64-n] is DES bit n (parity bits ignored)
//   decrypt_i     0 = K1..K16, 1 = K16..K1; sampled with an accepted start
//   start_i       start request, accepted while ready_o=1
//   ready_o       block can accept start_i (IDLE or DONE)
//   rkey_o[47:0]  current round key, rkey_o[48-n] is round-key bit n
//   rkey_valid_o  rkey_o holds a valid round key
//   rkey_ready_i  consumer accepts rkey_o when rkey_valid_o is also high
//   round_o[3:0]  position of the key on rkey_o in the issue order
//   done_o        one-cycle pulse after the 16th key transfer

module des_key_schedule (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [63:0] key_i,
  input  logic        decrypt_i,
  input  logic        start_i,
  output logic        ready_o,
  output logic [47:0] rkey_o,
  output logic        rkey_valid_o,
  input  logic        rkey_ready_i,
  output logic [3:0]  round_o,
  output logic        done_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Permuted choice tables, first table entry in the most significant slot.
  localparam logic [56*6-1:0] PC1_TAB = {
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
    6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
    6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
    6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
    6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
    6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
    6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
  };

  localparam logic [48*6-1:0] PC2_TAB = {
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  // DES bit n of the key lives at key[64-n]; with a 6-bit index 64-n == 0-n.
  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [56*6-1:0] tab;
    logic [55:0]     res;
    tab = PC1_TAB;
    res = '0;
    for (int i = 0; i < 56; i++) begin
      res = {res[54:0], key[6'd0 - tab[56*6-1 -: 6]]};
      tab = tab << 6;
    end
    return res;
  endfunction

  // CD bit n lives at cd[56-n].
  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [48*6-1:0] tab;
    logic [47:0]     res;
    tab = PC2_TAB;
    res = '0;
    for (int i = 0; i < 48; i++) begin
      res = {res[46:0], cd[6'd56 - tab[48*6-1 -: 6]]};
      tab = tab << 6;
    end
    return res;
  endfunction

  state_e      state_q, state_d;
  logic [27:0] c_q, c_d;
  logic [27:0] d_q, d_d;
  logic [3:0]  round_q, round_d;
  logic        dec_q, dec_d;

  logic        accept;
  logic        xfer;
  logic        single_shift;
  logic [55:0] cd_load;

  assign accept  = (state_q != ST_RUN) && start_i;
  assign xfer    = (state_q == ST_RUN) && rkey_ready_i;
  assign cd_load = pc1(key_i);

  // Rounds 0, 7, 14 and 15 are followed by a one-position rotate in both
  // directions: encrypt uses s(r+2), decrypt uses s(16-r), and both land on
  // the single-shift entries {1,2,9,16} for exactly these rounds.
  assign single_shift = (round_q == 4'd0) || (round_q == 4'd7) ||
                        (round_q == 4'd14) || (round_q == 4'd15);

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_RUN;
      ST_RUN:  if (rkey_ready_i && (round_q == 4'd15)) state_d = ST_DONE;
      ST_DONE: state_d = start_i ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    ready_o      = 1'b0;
    rkey_valid_o = 1'b0;
    done_o       = 1'b0;
    case (state_q)
      ST_IDLE: ready_o = 1'b1;
      ST_RUN:  rkey_valid_o = 1'b1;
      ST_DONE: begin
        ready_o = 1'b1;
        done_o  = 1'b1;
      end
      default: ready_o = 1'b0;
    endcase
  end

  assign rkey_o  = pc2({c_q, d_q});
  assign round_o = round_q;

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
    end else begin
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      dec_q   <= dec_d;
    end
  end

  always_comb begin
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    dec_d   = dec_q;
    if (accept) begin
      dec_d   = decrypt_i;
      round_d = 4'd0;
      if (decrypt_i) begin
        // Unrotated C0/D0 already yields K16.
        c_d = cd_load[55:28];
        d_d = cd_load[27:0];
      end else begin
        c_d = {cd_load[54:28], cd_load[55]};
        d_d = {cd_load[26:0],  cd_load[27]};
      end
    end else if (xfer) begin
      round_d = round_q + 4'd1;
      if (dec_q) begin
        c_d = single_shift ? {c_q[0], c_q[27:1]}   : {c_q[1:0], c_q[27:2]};
        d_d = single_shift ? {d_q[0], d_q[27:1]}   : {d_q[1:0], d_q[27:2]};
      end else begin
        c_d = single_shift ? {c_q[26:0], c_q[27]}  : {c_q[25:0], c_q[27:26]};
        d_d = single_shift ? {d_q[26:0], d_q[27]}  : {d_q[25:0], d_q[27:26]};
      end
    end
  end

endmodule

// File: tb/tb_des_key_schedule.sv
// tb/tb_des_key_schedule.sv - Self-checking bench for des_key_schedule

module tb_des_key_schedule;

  localparam int PC1_T [0:55] = '{
    57, 49, 41, 33, 25, 17, 9,  1,  58, 50, 42, 34, 26, 18,
    10, 2,  59, 51, 43, 35, 27, 19, 11, 3,  60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7,  62, 54, 46, 38, 30, 22,
    14, 6,  61, 53, 45, 37, 29, 21, 13, 5,  28, 20, 12, 4
  };

  localparam int PC2_T [0:47] = '{
    14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
    23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam logic [63:0] KNOWN_KEY = 64'h133457799BBCDFF1;
  localparam logic [47:0] KNOWN_K1  = 48'h1B02EFFC7072;
  localparam logic [47:0] KNOWN_K2  = 48'h79AED9DBC9E5;
  localparam logic [47:0] KNOWN_K16 = 48'hCB3D8B0E17F5;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [63:0] key_i = '0;
  logic        decrypt_i = 1'b0;
  logic        start_i = 1'b0;
  logic        ready_o;
  logic [47:0] rkey_o;
  logic        rkey_valid_o;
  logic        rkey_ready_i = 1'b0;
  logic [3:0]  round_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;

  logic [47:0] exp_keys [16];
  logic [47:0] got_keys [16];

  always #5 clk = ~clk;

  des_key_schedule dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .key_i        (key_i),
    .decrypt_i    (decrypt_i),
    .start_i      (start_i),
    .ready_o      (ready_o),
    .rkey_o       (rkey_o),
    .rkey_valid_o (rkey_valid_o),
    .rkey_ready_i (rkey_ready_i),
    .round_o      (round_o),
    .done_o       (done_o)
  );

  // Textbook Kj: PC-1, rotate C and D left by the cumulative shift count, PC-2.
  function automatic logic [47:0] model_key(input logic [63:0] k, input int j);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] r;
    int tot;
    for (int i = 0; i < 56; i++) cd[55 - i] = k[64 - PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    tot = 0;
    for (int m = 1; m <= j; m++) tot += (m == 1 || m == 2 || m == 9 || m == 16) ? 1 : 2;
    tot = tot % 28;
    for (int t = 0; t < tot; t++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    cd = {c, d};
    for (int i = 0; i < 48; i++) r[47 - i] = cd[56 - PC2_T[i]];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one full schedule from a ready state; returns at the DONE sample point.
  task automatic run_sched(input logic [63:0] key, input logic dec, input int pct, input bit poke);
    int r, cyc;
    logic [47:0] prev_key;
    logic [3:0]  prev_round;
    bit stalled;
    for (int j = 0; j < 16; j++) exp_keys[j] = dec ? model_key(key, 16 - j) : model_key(key, j + 1);
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL sched_ready_before_start: ready_o=%b required 1", ready_o);
    end
    key_i = key;
    decrypt_i = dec;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    r = 0;
    cyc = 0;
    stalled = 0;
    prev_key = '0;
    prev_round = '0;
    while (r < 16) begin
      if (cyc > 3000) begin
        checks++;
        errors++;
        $display("FAIL sched_timeout: reached round %0d required 16", r);
        break;
      end
      checks++;
      if (rkey_valid_o !== 1'b1 || round_o !== r[3:0]) begin
        errors++;
        $display("FAIL sched_valid_round: valid=%b round=%0d required valid=1 round=%0d", rkey_valid_o, round_o, r);
      end
      checks++;
      if (rkey_o !== exp_keys[r]) begin
        errors++;
        $display("FAIL sched_key r=%0d dec=%0b: got %h required %h", r, dec, rkey_o, exp_keys[r]);
      end
      if (stalled) begin
        checks++;
        if (rkey_o !== prev_key || round_o !== prev_round) begin
          errors++;
          $display("FAIL stall_hold: key=%h round=%0d required key=%h round=%0d", rkey_o, round_o, prev_key, prev_round);
        end
      end
      got_keys[r] = rkey_o;
      prev_key = rkey_o;
      prev_round = round_o;
      rkey_ready_i = ($urandom_range(0, 99) < pct);
      if (poke && $urandom_range(0, 2) == 0) begin
        start_i = 1'b1;
        decrypt_i = ~dec;
        key_i = ~key;
      end
      step();
      start_i = 1'b0;
      key_i = key;
      decrypt_i = dec;
      stalled = !rkey_ready_i;
      if (rkey_ready_i) r++;
      cyc++;
    end
    rkey_ready_i = 1'b0;
    checks++;
    if (done_o !== 1'b1 || ready_o !== 1'b1 || rkey_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL sched_done: done=%b ready=%b valid=%b required 1 1 0", done_o, ready_o, rkey_valid_o);
    end
    if (pct >= 100) begin
      checks++;
      if (cyc != 16) begin
        errors++;
        $display("FAIL sched_throughput: %0d cycles required 16", cyc);
      end
    end
  endtask

  task automatic check_idle_after(input string name);
    step();
    checks++;
    if (done_o !== 1'b0 || ready_o !== 1'b1 || rkey_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: done=%b ready=%b valid=%b required 0 1 0", name, done_o, ready_o, rkey_valid_o);
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    rst_ni = 1'b1;
    checks++;
    if (ready_o !== 1'b1 || rkey_valid_o !== 1'b0 || rkey_o !== 48'h0 || round_o !== 4'd0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: ready=%b valid=%b rkey=%h round=%0d done=%b required 1 0 0 0 0",
               ready_o, rkey_valid_o, rkey_o, round_o, done_o);
    end
    step();
    checks++;
    if (ready_o !== 1'b1 || rkey_valid_o !== 1'b0 || rkey_o !== 48'h0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: ready=%b valid=%b rkey=%h done=%b required 1 0 0 0", ready_o, rkey_valid_o, rkey_o, done_o);
    end
  endtask

  task automatic test_encrypt();
    run_sched(KNOWN_KEY, 1'b0, 100, 0);
    checks++;
    if (got_keys[0] !== KNOWN_K1 || got_keys[1] !== KNOWN_K2 || got_keys[15] !== KNOWN_K16) begin
      errors++;
      $display("FAIL enc_vectors: %h %h %h required %h %h %h", got_keys[0], got_keys[1], got_keys[15], KNOWN_K1, KNOWN_K2, KNOWN_K16);
    end
    check_idle_after("enc");
  endtask

  task automatic test_decrypt();
    run_sched(KNOWN_KEY, 1'b1, 100, 0);
    checks++;
    if (got_keys[0] !== KNOWN_K16 || got_keys[14] !== KNOWN_K2 || got_keys[15] !== KNOWN_K1) begin
      errors++;
      $display("FAIL dec_vectors: %h %h %h required %h %h %h", got_keys[0], got_keys[14], got_keys[15], KNOWN_K16, KNOWN_K2, KNOWN_K1);
    end
    check_idle_after("dec");
  endtask

  task automatic test_backpressure();
    run_sched(KNOWN_KEY, 1'b0, 30, 0);
    checks++;
    if (got_keys[0] !== KNOWN_K1 || got_keys[15] !== KNOWN_K16) begin
      errors++;
      $display("FAIL bp_vectors: %h %h required %h %h", got_keys[0], got_keys[15], KNOWN_K1, KNOWN_K16);
    end
    check_idle_after("bp");
    for (int n = 0; n < 4; n++) begin
      run_sched({$urandom, $urandom}, 1'($urandom_range(0, 1)), 30, 0);
      check_idle_after("bp_rand");
    end
  endtask

  task automatic test_parity();
    logic [63:0] pk [2];
    pk[0] = 64'h0101010101010101;
    pk[1] = 64'h0;
    for (int n = 0; n < 2; n++) begin
      run_sched(pk[n], 1'b0, 100, 0);
      for (int j = 0; j < 16; j++) begin
        checks++;
        if (got_keys[j] !== 48'h0) begin
          errors++;
          $display("FAIL parity_zero key=%h r=%0d: got %h required 0", pk[n], j, got_keys[j]);
        end
      end
      check_idle_after("parity");
    end
  endtask

  task automatic test_start_during_run();
    run_sched(KNOWN_KEY, 1'b0, 60, 1);
    check_idle_after("poke_enc");
    run_sched({$urandom, $urandom}, 1'b1, 100, 1);
    check_idle_after("poke_dec");
  endtask

  task automatic test_back_to_back();
    run_sched({$urandom, $urandom}, 1'b0, 100, 0);
    run_sched({$urandom, $urandom}, 1'b1, 100, 0);
    run_sched(KNOWN_KEY, 1'b0, 100, 0);
    checks++;
    if (got_keys[0] !== KNOWN_K1) begin
      errors++;
      $display("FAIL b2b_first: got %h required %h", got_keys[0], KNOWN_K1);
    end
    check_idle_after("b2b");
  endtask

  task automatic test_reset_mid_run();
    int guard;
    key_i = KNOWN_KEY;
    decrypt_i = 1'b0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    rkey_ready_i = 1'b1;
    guard = 0;
    while (round_o !== 4'd7 && guard < 50) begin
      step();
      guard++;
    end
    checks++;
    if (round_o !== 4'd7 || rkey_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_reach_r7: round=%0d valid=%b required 7 1", round_o, rkey_valid_o);
    end
    rst_ni = 1'b0;
    step();
    checks++;
    if (ready_o !== 1'b1 || rkey_valid_o !== 1'b0 || round_o !== 4'd0 || rkey_o !== 48'h0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_run: ready=%b valid=%b round=%0d rkey=%h done=%b required 1 0 0 0 0",
               ready_o, rkey_valid_o, round_o, rkey_o, done_o);
    end
    rst_ni = 1'b1;
    rkey_ready_i = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step();
      checks++;
      if (done_o !== 1'b0 || rkey_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL rst_no_done: done=%b valid=%b required 0 0", done_o, rkey_valid_o);
      end
    end
    run_sched(KNOWN_KEY, 1'b0, 100, 0);
    checks++;
    if (got_keys[0] !== KNOWN_K1) begin
      errors++;
      $display("FAIL rst_restart_k1: got %h required %h", got_keys[0], KNOWN_K1);
    end
    check_idle_after("rst");
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_parity();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
